pipe_hazard_fwd: RTL and testbench

Parametrised combined hazard-detection and forwarding unit for the pipelined core. It replaces the separate hazard and forwarding stubs. It keeps an in-flight scoreboard of the DEPTH instructions downstream of ID, resolves RAW dependencies for the instruction in ID, muxes forwarded operands, raises load-use stalls, inserts bubbles, and counts stall cycles.

---
 rtl/pipe_hazard_fwd.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_fwd.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_fwd.sv
// Combined hazard detection and operand forwarding for the ID stage.
// A small scoreboard mirrors the DEPTH instructions downstream of ID
// (position 1 = EX ... DEPTH = last position before retirement). Each
// source of the ID instruction is resolved against it: the youngest
// in-flight writer wins. A ready writer is forwarded. A writer that is
// not ready yet (a load before LOAD_LAT) stalls ID and sends a bubble down.
module pipe_hazard_fwd #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  localparam int RW = $clog2(NREG),
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [RW-1:0]         id_rs1,
  input  logic [RW-1:0]         id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [RW-1:0]         id_rd,
  input  logic                  id_rd_wen,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  ext_stall,
  input  logic [XLEN-1:0]       rf_rs1data,
  input  logic [XLEN-1:0]       rf_rs2data,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  output logic [XLEN-1:0]       opa,
  output logic [XLEN-1:0]       opb,
  output logic [SW-1:0]         fwd_sel1,
  output logic [SW-1:0]         fwd_sel2,
  output logic                  hold_pc,
  output logic [31:0]           stall_cnt
);

  // Scoreboard, indexed by pipeline position 1..DEPTH.
  logic [DEPTH:1]         sb_v;
  logic [DEPTH:1]         sb_wen;
  logic [DEPTH:1]         sb_ld;
  logic [DEPTH:1][RW-1:0] sb_rd;

  logic [SW-1:0] sel1;
  logic [SW-1:0] sel2;
  logic          haz1;
  logic          haz2;
  logic          hazard;
  logic          issue;

  // Dependency resolution. Positions are scanned oldest to youngest so the
  // last hit (lowest position) decides both the select and the hazard.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (sb_v[k] && sb_wen[k] && id_rs1_used && (id_rs1 != '0) &&
          (sb_rd[k] == id_rs1)) begin
        if (k >= (sb_ld[k] ? LOAD_LAT : 1)) begin
          sel1 = SW'(k);
          haz1 = 1'b0;
        end else begin
          sel1 = '0;
          haz1 = 1'b1;
        end
      end
      if (sb_v[k] && sb_wen[k] && id_rs2_used && (id_rs2 != '0) &&
          (sb_rd[k] == id_rs2)) begin
        if (k >= (sb_ld[k] ? LOAD_LAT : 1)) begin
          sel2 = SW'(k);
          haz2 = 1'b0;
        end else begin
          sel2 = '0;
          haz2 = 1'b1;
        end
      end
    end
  end

  // Operand muxes: register file unless a position is selected.
  always_comb begin
    opa = rf_rs1data;
    opb = rf_rs2data;
    for (int k = 1; k <= DEPTH; k++) begin
      if (sel1 == SW'(k)) opa = stage_data[(k-1)*XLEN +: XLEN];
      if (sel2 == SW'(k)) opb = stage_data[(k-1)*XLEN +: XLEN];
    end
  end

  assign fwd_sel1 = sel1;
  assign fwd_sel2 = sel2;
  assign hazard   = id_valid && (haz1 || haz2);
  // A taken branch discards the ID instruction, so its hazard is moot;
  // a downstream wait freezes everything regardless.
  assign hold_pc  = ext_stall || (hazard && !flush);
  assign issue    = id_valid && !hazard && !flush;

  // Scoreboard shift: the ID instruction (or a bubble) enters position 1,
  // the oldest entry retires; frozen while memory is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_v   <= '0;
      sb_wen <= '0;
      sb_ld  <= '0;
      sb_rd  <= '0;
    end else if (!ext_stall) begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_v[k]   <= sb_v[k-1];
        sb_wen[k] <= sb_wen[k-1];
        sb_ld[k]  <= sb_ld[k-1];
        sb_rd[k]  <= sb_rd[k-1];
      end
      sb_v[1]   <= issue;
      sb_wen[1] <= id_rd_wen;
      sb_ld[1]  <= id_is_load;
      sb_rd[1]  <= id_rd;
    end
  end

  // Saturating count of cycles lost to unresolved dependencies only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hazard && !flush && !ext_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_fwd.sv
// Bench for pipe_hazard_fwd: directed vector table, an async reset
// sequence, then random traffic checked against a queue-based model.
module tb_pipe_hazard_fwd;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int RW       = 5;
  localparam int SW       = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  id_valid;
  logic [RW-1:0]         id_rs1;
  logic [RW-1:0]         id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [RW-1:0]         id_rd;
  logic                  id_rd_wen;
  logic                  id_is_load;
  logic                  flush;
  logic                  ext_stall;
  logic [XLEN-1:0]       rf_rs1data;
  logic [XLEN-1:0]       rf_rs2data;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic [XLEN-1:0]       opa;
  logic [XLEN-1:0]       opb;
  logic [SW-1:0]         fwd_sel1;
  logic [SW-1:0]         fwd_sel2;
  logic                  hold_pc;
  logic [31:0]           stall_cnt;

  pipe_hazard_fwd #(
    .XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
    .flush(flush), .ext_stall(ext_stall),
    .rf_rs1data(rf_rs1data), .rf_rs2data(rf_rs2data), .stage_data(stage_data),
    .opa(opa), .opb(opb), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .hold_pc(hold_pc), .stall_cnt(stall_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic v, input int rs1, input int rs2, input logic u1,
                       input logic u2, input int rd, input logic wen, input logic ld,
                       input logic fl, input logic es);
    id_valid    = v;
    id_rs1      = RW'(rs1);
    id_rs2      = RW'(rs2);
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = RW'(rd);
    id_rd_wen   = wen;
    id_is_load  = ld;
    flush       = fl;
    ext_stall   = es;
  endtask

  function automatic logic [XLEN-1:0] exp_op(input int sel, input logic [XLEN-1:0] rf);
    if (sel == 0) return rf;
    return stage_data[(sel-1)*XLEN +: XLEN];
  endfunction

  // Directed vector table
  typedef struct {
    logic v; int rs1; int rs2; logic u1; logic u2; int rd; logic wen; logic ld;
    logic fl; logic es; int s1; int s2; logic h; int cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input int rs1, input int rs2, input logic u1,
                     input logic u2, input int rd, input logic wen, input logic ld,
                     input logic fl, input logic es, input int s1, input int s2,
                     input logic h, input int cnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.wen = wen; r.ld = ld; r.fl = fl; r.es = es;
    r.s1 = s1; r.s2 = s2; r.h = h; r.cnt = cnt;
    tbl.push_back(r);
  endtask

  // Reference model: in-flight instructions, front = youngest (position 1).
  typedef struct { bit v; int rd; bit wen; bit ld; } ent_t;
  ent_t pq[$];
  logic [31:0] cnt_m;

  task automatic model_reset();
    ent_t b;
    b.v = 0; b.rd = 0; b.wen = 0; b.ld = 0;
    pq.delete();
    for (int i = 0; i < DEPTH; i++) pq.push_back(b);
    cnt_m = '0;
  endtask

  // Youngest writer of src decides: forwarded if its result exists yet.
  task automatic model_find(input int src, input bit used, output int sel, output bit haz);
    sel = 0;
    haz = 0;
    if (used && src != 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pq[i].v && pq[i].wen && pq[i].rd == src) begin
          if (i + 1 >= (pq[i].ld ? LOAD_LAT : 1)) sel = i + 1;
          else haz = 1;
          break;
        end
      end
    end
  endtask

  initial begin
    int s1, s2;
    bit h1, h2, hz;
    ent_t e;

    // Reset
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rf_rs1data = 32'h1111_1111;
    rf_rs2data = 32'h2222_2222;
    stage_data = {32'h0000_5555, 32'h0000_BBBB, 32'h0000_AAAA};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    add(0,0,0,0,0, 0,0,0, 0,0,  0,0,0,0);
    add(1,0,0,0,0, 5,1,0, 0,0,  0,0,0,0);
    add(1,5,0,1,0, 0,0,0, 0,0,  1,0,0,0);
    add(1,5,0,1,0, 7,1,1, 0,0,  2,0,0,0);
    add(1,5,7,1,1, 9,1,0, 0,0,  3,0,1,0);
    add(1,5,7,1,1, 9,1,0, 0,0,  0,2,0,1);
    add(1,0,0,0,0, 3,1,0, 0,0,  0,0,0,1);
    add(0,0,0,0,0, 0,0,0, 0,0,  0,0,0,1);
    add(1,0,0,0,0, 3,1,0, 0,0,  0,0,0,1);
    add(1,3,0,1,1, 7,1,1, 0,0,  1,0,0,1);
    add(1,0,7,1,0, 7,1,1, 0,0,  0,0,0,1);
    add(1,7,0,1,0, 0,0,0, 1,0,  0,0,0,1);
    add(1,7,0,1,0, 0,0,0, 0,0,  2,0,0,1);
    add(1,0,0,0,0, 0,1,0, 0,0,  0,0,0,1);
    add(1,0,0,1,0, 4,1,1, 0,0,  0,0,0,1);
    add(1,0,4,0,1, 0,0,0, 0,1,  0,0,1,1);
    add(0,0,0,0,0, 0,0,0, 0,1,  0,0,1,1);
    add(0,4,0,1,0, 0,0,0, 0,1,  0,0,1,1);
    add(1,0,4,0,1, 0,0,0, 0,0,  0,0,1,1);
    add(1,0,4,0,1, 0,0,0, 0,0,  0,2,0,2);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
            tbl[i].rd, tbl[i].wen, tbl[i].ld, tbl[i].fl, tbl[i].es);
      #1;
      check($sformatf("row%0d sel1", i), 32'(fwd_sel1), 32'(tbl[i].s1));
      check($sformatf("row%0d sel2", i), 32'(fwd_sel2), 32'(tbl[i].s2));
      check($sformatf("row%0d hold", i), 32'(hold_pc), 32'(tbl[i].h));
      check($sformatf("row%0d cnt", i), stall_cnt, 32'(tbl[i].cnt));
      check($sformatf("row%0d opa", i), opa, exp_op(tbl[i].s1, rf_rs1data));
      check($sformatf("row%0d opb", i), opb, exp_op(tbl[i].s2, rf_rs2data));
    end

    // Async reset mid-operation: entries and counter drop before any edge.
    @(negedge clk);
    drive(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst sel1", 32'(fwd_sel1), 32'd3);
    check("pre_rst cnt", stall_cnt, 32'd2);
    #1 rst = 1'b1;
    #1;
    check("rst sel1", 32'(fwd_sel1), 32'd0);
    check("rst opa", opa, rf_rs1data);
    check("rst cnt", stall_cnt, 32'd0);
    check("rst hold", 32'(hold_pc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst sel1", 32'(fwd_sel1), 32'd0);

    // Random traffic against the model.
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      rf_rs1data = $urandom;
      rf_rs2data = $urandom;
      stage_data = {$urandom, $urandom, $urandom};
      #1;
      model_find(int'(id_rs1), id_rs1_used, s1, h1);
      model_find(int'(id_rs2), id_rs2_used, s2, h2);
      hz = id_valid && (h1 || h2);
      exp_q.push_back(exp_op(s1, rf_rs1data));
      exp_q.push_back(exp_op(s2, rf_rs2data));
      check($sformatf("rnd%0d sel1", i), 32'(fwd_sel1), 32'(s1));
      check($sformatf("rnd%0d sel2", i), 32'(fwd_sel2), 32'(s2));
      check($sformatf("rnd%0d hold", i), 32'(hold_pc), 32'(ext_stall || (hz && !flush)));
      check($sformatf("rnd%0d cnt", i), stall_cnt, cnt_m);
      check($sformatf("rnd%0d opa", i), opa, exp_q.pop_front());
      check($sformatf("rnd%0d opb", i), opb, exp_q.pop_front());
      // Model state for the coming edge.
      if (!ext_stall) begin
        e.v = id_valid && !hz && !flush;
        e.rd = int'(id_rd);
        e.wen = id_rd_wen;
        e.ld = id_is_load;
        void'(pq.pop_back());
        pq.push_front(e);
        if (hz && !flush && cnt_m != 32'hFFFF_FFFF) cnt_m++;
      end
    end

    // Report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
